// File: rtl/cdb_pkg.sv
// cdb_pkg: CDB packet type shared by the arbiter, ROB and reservation-station
// snoop logic, plus default sizing for the arbiter.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

package cdb_pkg;

    localparam int unsigned XLEN        = `XLEN;
    localparam int unsigned ROB_TAG_LEN = `ROB_TAG_LEN;

    localparam int unsigned CDB_DEF_NUM_FU    = 4;
    localparam int unsigned CDB_DEF_NUM_CDB   = 1;
    localparam int unsigned CDB_DEF_BUF_DEPTH = 2;

    typedef struct packed {
        logic [XLEN-1:0]        value;
        logic [ROB_TAG_LEN-1:0] tag;
        logic                   mis_predict;
        logic [XLEN-1:0]        target_pc;
    } cdb_packet_t;

endpackage

// File: rtl/cdb_fifo.sv
// cdb_fifo: per-FU circular result buffer. Pointers wrap at DEPTH (any
// integer), and a simultaneous push/pop leaves the occupancy unchanged.
module cdb_fifo
    import cdb_pkg::*;
#(
    parameter  int unsigned DEPTH = CDB_DEF_BUF_DEPTH,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_squash,
    input  logic          i_push,
    input  cdb_packet_t   i_data,
    input  logic          i_pop,
    output cdb_packet_t   o_head,
    output logic [CW-1:0] o_count
);

    localparam int unsigned   PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    cdb_packet_t   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push && (r_count < CW'(DEPTH));
    assign w_pop   = i_pop && (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Pointer and occupancy update; a flush also drops any same-cycle push
    always_ff @(posedge i_clk) begin
        if (i_rst || i_squash) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; no reset needed because occupancy gates every read
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers FU results in per-FU FIFOs and drains up to NUM_CDB
// heads per cycle, round-robin, onto registered broadcast channels.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int unsigned NUM_FU    = CDB_DEF_NUM_FU,
    parameter int unsigned NUM_CDB   = CDB_DEF_NUM_CDB,
    parameter int unsigned BUF_DEPTH = CDB_DEF_BUF_DEPTH
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  squash,
    input  logic [NUM_FU-1:0]                     fu_valid,
    input  logic [NUM_FU-1:0][XLEN-1:0]           fu_value,
    input  logic [NUM_FU-1:0][ROB_TAG_LEN-1:0]    fu_tag,
    input  logic [NUM_FU-1:0]                     fu_mis_predict,
    input  logic [NUM_FU-1:0][XLEN-1:0]           fu_target_pc,
    output logic [NUM_FU-1:0]                     fu_ready,
    output logic [NUM_CDB-1:0]                    cdb_valid,
    output logic [NUM_CDB-1:0][XLEN-1:0]          cdb_value,
    output logic [NUM_CDB-1:0][ROB_TAG_LEN-1:0]   cdb_tag,
    output logic [NUM_CDB-1:0][$clog2(NUM_FU)-1:0] cdb_fu,
    output logic [NUM_CDB-1:0]                    cdb_mis_predict,
    output logic [NUM_CDB-1:0][XLEN-1:0]          cdb_target_pc,
    output logic                                  rob_enable
);

    localparam int unsigned FUW = $clog2(NUM_FU);
    localparam int unsigned CW  = $clog2(BUF_DEPTH + 1);

    cdb_packet_t       w_head     [NUM_FU];
    logic [CW-1:0]     w_count    [NUM_FU];
    logic [NUM_FU-1:0] w_nonempty;
    logic [NUM_FU-1:0] w_grant;
    int unsigned       w_dist     [NUM_FU];
    int unsigned       w_rank     [NUM_FU];
    logic [NUM_CDB-1:0] w_ch_valid;
    logic [FUW-1:0]    w_ch_fu    [NUM_CDB];
    cdb_packet_t       w_ch_pkt   [NUM_CDB];
    logic [FUW-1:0]    r_rr_ptr;
    logic [FUW-1:0]    w_rr_next;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
        cdb_packet_t w_in;

        assign w_in = '{value:       fu_value[i],
                        tag:         fu_tag[i],
                        mis_predict: fu_mis_predict[i],
                        target_pc:   fu_target_pc[i]};

        assign fu_ready[i]   = (w_count[i] < CW'(BUF_DEPTH));
        assign w_nonempty[i] = (w_count[i] != '0);

        cdb_fifo #(
            .DEPTH (BUF_DEPTH)
        ) u_fifo (
            .i_clk    (clock),
            .i_rst    (reset),
            .i_squash (squash),
            .i_push   (fu_valid[i] && fu_ready[i]),
            .i_data   (w_in),
            .i_pop    (w_grant[i]),
            .o_head   (w_head[i]),
            .o_count  (w_count[i])
        );
    end

    // Round-robin grant: an FU's rank is the number of non-empty FIFOs ahead
    // of it in scan order from r_rr_ptr; rank doubles as its channel index.
    always_comb begin
        w_grant    = '0;
        w_ch_valid = '0;
        w_rr_next  = r_rr_ptr;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            w_dist[i] = (i + NUM_FU - 32'(r_rr_ptr)) % NUM_FU;
        end
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            w_rank[i] = 0;
            for (int unsigned j = 0; j < NUM_FU; j++) begin
                if (w_nonempty[j] && (w_dist[j] < w_dist[i])) begin
                    w_rank[i] = w_rank[i] + 1;
                end
            end
            w_grant[i] = w_nonempty[i] && (w_rank[i] < NUM_CDB);
        end
        for (int unsigned c = 0; c < NUM_CDB; c++) begin
            w_ch_fu[c]  = '0;
            w_ch_pkt[c] = '0;
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (w_grant[i] && (w_rank[i] == c)) begin
                    w_ch_valid[c] = 1'b1;
                    w_ch_fu[c]    = FUW'(i);
                    w_ch_pkt[c]   = w_head[i];
                    w_rr_next     = FUW'((i + 1) % NUM_FU);
                end
            end
        end
    end

    // Broadcast registers; idle channels load all-zero packets
    always_ff @(posedge clock) begin
        if (reset || squash) begin
            cdb_valid       <= '0;
            cdb_value       <= '0;
            cdb_tag         <= '0;
            cdb_fu          <= '0;
            cdb_mis_predict <= '0;
            cdb_target_pc   <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CDB; c++) begin
                cdb_valid[c]       <= w_ch_valid[c];
                cdb_value[c]       <= w_ch_pkt[c].value;
                cdb_tag[c]         <= w_ch_pkt[c].tag;
                cdb_fu[c]          <= w_ch_fu[c];
                cdb_mis_predict[c] <= w_ch_pkt[c].mis_predict;
                cdb_target_pc[c]   <= w_ch_pkt[c].target_pc;
            end
        end
    end

    // Scan pointer survives a squash; only reset returns it to FU 0
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (!squash) begin
            r_rr_ptr <= w_rr_next;
        end
    end

    assign rob_enable = |cdb_valid;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vectors against a default cdb_arbiter (4 FU,
// 1 channel, depth 2) and a wide one (4 FU, 2 channels, depth 3).
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int unsigned NFU = 4;

    logic clock = 1'b0;
    logic reset;
    logic squash;

    always #5 clock = ~clock;

    // Instance A: defaults
    logic [NFU-1:0]                  a_valid;
    logic [NFU-1:0][XLEN-1:0]        a_value;
    logic [NFU-1:0][ROB_TAG_LEN-1:0] a_tag;
    logic [NFU-1:0]                  a_mis;
    logic [NFU-1:0][XLEN-1:0]        a_tpc;
    logic [NFU-1:0]                  a_ready;
    logic [0:0]                      a_cvalid;
    logic [0:0][XLEN-1:0]            a_cvalue;
    logic [0:0][ROB_TAG_LEN-1:0]     a_ctag;
    logic [0:0][1:0]                 a_cfu;
    logic [0:0]                      a_cmis;
    logic [0:0][XLEN-1:0]            a_ctpc;
    logic                            a_rob;

    // Instance B: two channels, non-power-of-two depth
    logic [NFU-1:0]                  b_valid;
    logic [NFU-1:0][XLEN-1:0]        b_value;
    logic [NFU-1:0][ROB_TAG_LEN-1:0] b_tag;
    logic [NFU-1:0]                  b_mis;
    logic [NFU-1:0][XLEN-1:0]        b_tpc;
    logic [NFU-1:0]                  b_ready;
    logic [1:0]                      b_cvalid;
    logic [1:0][XLEN-1:0]            b_cvalue;
    logic [1:0][ROB_TAG_LEN-1:0]     b_ctag;
    logic [1:0][1:0]                 b_cfu;
    logic [1:0]                      b_cmis;
    logic [1:0][XLEN-1:0]            b_ctpc;
    logic                            b_rob;

    cdb_arbiter #(
        .NUM_FU    (4),
        .NUM_CDB   (1),
        .BUF_DEPTH (2)
    ) u_dut_a (
        .clock           (clock),
        .reset           (reset),
        .squash          (squash),
        .fu_valid        (a_valid),
        .fu_value        (a_value),
        .fu_tag          (a_tag),
        .fu_mis_predict  (a_mis),
        .fu_target_pc    (a_tpc),
        .fu_ready        (a_ready),
        .cdb_valid       (a_cvalid),
        .cdb_value       (a_cvalue),
        .cdb_tag         (a_ctag),
        .cdb_fu          (a_cfu),
        .cdb_mis_predict (a_cmis),
        .cdb_target_pc   (a_ctpc),
        .rob_enable      (a_rob)
    );

    cdb_arbiter #(
        .NUM_FU    (4),
        .NUM_CDB   (2),
        .BUF_DEPTH (3)
    ) u_dut_b (
        .clock           (clock),
        .reset           (reset),
        .squash          (squash),
        .fu_valid        (b_valid),
        .fu_value        (b_value),
        .fu_tag          (b_tag),
        .fu_mis_predict  (b_mis),
        .fu_target_pc    (b_tpc),
        .fu_ready        (b_ready),
        .cdb_valid       (b_cvalid),
        .cdb_value       (b_cvalue),
        .cdb_tag         (b_ctag),
        .cdb_fu          (b_cfu),
        .cdb_mis_predict (b_cmis),
        .cdb_target_pc   (b_ctpc),
        .rob_enable      (b_rob)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_a(input string nm, input logic v, input logic [1:0] fu,
                         input logic [ROB_TAG_LEN-1:0] t, input logic [XLEN-1:0] val,
                         input logic mis, input logic [XLEN-1:0] tpc);
        chk({nm, ".valid"}, 64'(a_cvalid[0]), 64'(v));
        chk({nm, ".fu"},    64'(a_cfu[0]),    64'(fu));
        chk({nm, ".tag"},   64'(a_ctag[0]),   64'(t));
        chk({nm, ".value"}, 64'(a_cvalue[0]), 64'(val));
        chk({nm, ".mis"},   64'(a_cmis[0]),   64'(mis));
        chk({nm, ".tpc"},   64'(a_ctpc[0]),   64'(tpc));
        chk({nm, ".rob"},   64'(a_rob),       64'(v));
    endtask

    task automatic a_idle(input string nm);
        chk_a(nm, 1'b0, 2'd0, '0, '0, 1'b0, '0);
    endtask

    task automatic chk_b(input string nm, input logic ch, input logic v, input logic [1:0] fu,
                         input logic [ROB_TAG_LEN-1:0] t, input logic [XLEN-1:0] val);
        chk({nm, ".valid"}, 64'(b_cvalid[ch]), 64'(v));
        chk({nm, ".fu"},    64'(b_cfu[ch]),    64'(fu));
        chk({nm, ".tag"},   64'(b_ctag[ch]),   64'(t));
        chk({nm, ".value"}, 64'(b_cvalue[ch]), 64'(val));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_inputs();
        a_valid = '0; a_value = '0; a_tag = '0; a_mis = '0; a_tpc = '0;
        b_valid = '0; b_value = '0; b_tag = '0; b_mis = '0; b_tpc = '0;
    endtask

    task automatic a_drive(input logic [1:0] i, input logic [XLEN-1:0] val,
                           input logic [ROB_TAG_LEN-1:0] t, input logic mis,
                           input logic [XLEN-1:0] tpc);
        a_valid[i] = 1'b1;
        a_value[i] = val;
        a_tag[i]   = t;
        a_mis[i]   = mis;
        a_tpc[i]   = tpc;
    endtask

    task automatic b_drive(input logic [1:0] i, input logic [XLEN-1:0] val,
                           input logic [ROB_TAG_LEN-1:0] t);
        b_valid[i] = 1'b1;
        b_value[i] = val;
        b_tag[i]   = t;
        b_mis[i]   = 1'b0;
        b_tpc[i]   = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        reset  = 1'b1;
        squash = 1'b0;
        clr_inputs();
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        a_idle("rst");
        chk("rst.ready", 64'(a_ready), 64'hF);
        chk("rst.b_valid", 64'(b_cvalid), 64'h0);
        chk("rst.b_ready", 64'(b_ready), 64'hF);
        tick();
        a_idle("idle");

        // Single push: FU2 0xDEAD tag 5, visible two edges later for one cycle
        a_drive(2'd2, 32'hDEAD, ROB_TAG_LEN'(5), 1'b0, '0);
        tick();
        clr_inputs();
        a_idle("single.e0");
        tick();
        chk_a("single.e1", 1'b1, 2'd2, ROB_TAG_LEN'(5), 32'hDEAD, 1'b0, '0);
        tick();
        a_idle("single.e2");

        // Two bursts of four from rr_ptr=0: FU order 0,1,2,3 each time
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) begin
                a_drive(2'(i), XLEN'(32'h100 * (b + 1) + i), ROB_TAG_LEN'(4 * b + i + 1), 1'b0, '0);
            end
            tick();
            clr_inputs();
            a_idle("burst.e0");
            for (int k = 0; k < 4; k++) begin
                tick();
                chk_a("burst", 1'b1, 2'(k), ROB_TAG_LEN'(4 * b + k + 1),
                      XLEN'(32'h100 * (b + 1) + k), 1'b0, '0);
            end
            tick();
            a_idle("burst.end");
        end

        // Back-pressure on FU0 (depth 2) while FU1..3 occupy the bus; rr_ptr=0
        for (int i = 1; i < 4; i++) begin
            a_drive(2'(i), XLEN'(32'h20 + i), ROB_TAG_LEN'(20 + i), 1'b0, '0);
        end
        tick();
        clr_inputs();
        chk("bp.ready_a", 64'(a_ready), 64'hF);
        a_drive(2'd0, 32'h10, ROB_TAG_LEN'(10), 1'b0, '0);
        tick();
        chk_a("bp.b", 1'b1, 2'd1, ROB_TAG_LEN'(21), 32'h21, 1'b0, '0);
        a_drive(2'd0, 32'h11, ROB_TAG_LEN'(11), 1'b0, '0);
        tick();
        chk_a("bp.c", 1'b1, 2'd2, ROB_TAG_LEN'(22), 32'h22, 1'b0, '0);
        chk("bp.ready0_full_c", 64'(a_ready[0]), 64'h0);
        a_drive(2'd0, 32'h12, ROB_TAG_LEN'(12), 1'b0, '0);
        tick();
        chk_a("bp.d", 1'b1, 2'd3, ROB_TAG_LEN'(23), 32'h23, 1'b0, '0);
        chk("bp.ready0_full_d", 64'(a_ready[0]), 64'h0);
        tick();
        chk_a("bp.e", 1'b1, 2'd0, ROB_TAG_LEN'(10), 32'h10, 1'b0, '0);
        chk("bp.ready0_e", 64'(a_ready[0]), 64'h1);
        tick();
        clr_inputs();
        chk_a("bp.f", 1'b1, 2'd0, ROB_TAG_LEN'(11), 32'h11, 1'b0, '0);
        tick();
        chk_a("bp.g", 1'b1, 2'd0, ROB_TAG_LEN'(12), 32'h12, 1'b0, '0);
        tick();
        a_idle("bp.h");

        // Branch packet and squash; rr_ptr=1 here
        a_drive(2'd0, 32'h30, ROB_TAG_LEN'(30), 1'b0, '0);
        a_drive(2'd1, 32'h31, ROB_TAG_LEN'(31), 1'b0, '0);
        a_drive(2'd3, 32'h33, ROB_TAG_LEN'(33), 1'b0, '0);
        tick();
        clr_inputs();
        a_drive(2'd0, 32'h34, ROB_TAG_LEN'(34), 1'b0, '0);
        a_drive(2'd2, 32'h77, ROB_TAG_LEN'(7), 1'b1, 32'h400);
        tick();
        clr_inputs();
        chk_a("sq.p1", 1'b1, 2'd1, ROB_TAG_LEN'(31), 32'h31, 1'b0, '0);
        chk("sq.ready_p1", 64'(a_ready), 64'hE);
        tick();
        chk_a("sq.btu", 1'b1, 2'd2, ROB_TAG_LEN'(7), 32'h77, 1'b1, 32'h400);
        squash = 1'b1;
        a_drive(2'd1, 32'h50, ROB_TAG_LEN'(50), 1'b0, '0);
        tick();
        squash = 1'b0;
        clr_inputs();
        a_idle("sq.flush");
        chk("sq.ready", 64'(a_ready), 64'hF);
        tick();
        a_idle("sq.after");
        a_drive(2'd0, 32'h60, ROB_TAG_LEN'(60), 1'b0, '0);
        a_drive(2'd3, 32'h63, ROB_TAG_LEN'(63), 1'b0, '0);
        tick();
        clr_inputs();
        tick();
        chk_a("sq.rr_kept0", 1'b1, 2'd3, ROB_TAG_LEN'(63), 32'h63, 1'b0, '0);
        tick();
        chk_a("sq.rr_kept1", 1'b1, 2'd0, ROB_TAG_LEN'(60), 32'h60, 1'b0, '0);

        // Two channels: FU1 and FU3 in the same cycle
        b_drive(2'd1, 32'hB1, ROB_TAG_LEN'(11));
        b_drive(2'd3, 32'hB3, ROB_TAG_LEN'(13));
        tick();
        clr_inputs();
        chk("dual.e0", 64'(b_cvalid), 64'h0);
        tick();
        chk_b("dual.ch0", 1'b0, 1'b1, 2'd1, ROB_TAG_LEN'(11), 32'hB1);
        chk_b("dual.ch1", 1'b1, 1'b1, 2'd3, ROB_TAG_LEN'(13), 32'hB3);
        chk("dual.rob", 64'(b_rob), 64'h1);
        tick();
        chk("dual.e2", 64'(b_cvalid), 64'h0);

        // Depth-3 stream on FU0: pointers wrap at 3, order preserved
        for (int k = 0; k < 5; k++) begin
            b_drive(2'd0, XLEN'(32'h40 + k), ROB_TAG_LEN'(40 + k));
            tick();
            if (k > 0) begin
                chk_b("wrap.ch0", 1'b0, 1'b1, 2'd0, ROB_TAG_LEN'(40 + k - 1), XLEN'(32'h40 + k - 1));
                chk_b("wrap.ch1", 1'b1, 1'b0, 2'd0, '0, '0);
            end
        end
        clr_inputs();
        tick();
        chk_b("wrap.last", 1'b0, 1'b1, 2'd0, ROB_TAG_LEN'(44), 32'h44);
        chk("wrap.ready", 64'(b_ready), 64'hF);
        tick();
        chk("wrap.idle", 64'(b_cvalid), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Parametrised, buffered common data bus arbiter between the functional units and the ROB/reservation stations. Each FU owns a small result FIFO with ready/valid back-pressure. A round-robin arbiter drains up to NUM_CDB FIFO heads per cycle onto registered broadcast channels. Branch resolution data (mispredict flag, target PC) travels with each packet, and a squash input flushes every pending result.

## Interface
Parameters:
- NUM_FU, 4, number of FU result ports (≥2)
- NUM_CDB, 1, broadcast channels per cycle (1 ≤ NUM_CDB ≤ NUM_FU)
- BUF_DEPTH, 2, entries per FU FIFO (≥1, any integer)

Ports:
- clock  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high
- squash  in  1  pipeline flush; discard everything pending
- fu_valid  in  [NUM_FU]  FU presents a result
- fu_value  in  [NUM_FU][`XLEN]  result value
- fu_tag  in  [NUM_FU][`ROB_TAG_LEN]  destination ROB tag
- fu_mis_predict  in  [NUM_FU]  branch mispredicted (0 for non-branch FUs)
- fu_target_pc  in  [NUM_FU][`XLEN]  resolved branch target (0 for non-branch FUs)
- fu_ready  out  [NUM_FU]  FIFO can accept this cycle
- cdb_valid  out  [NUM_CDB]  channel carries a result
- cdb_value  out  [NUM_CDB][`XLEN]  broadcast value
- cdb_tag  out  [NUM_CDB][`ROB_TAG_LEN]  broadcast tag
- cdb_fu  out  [NUM_CDB][$clog2(NUM_FU)]  source FU index
- cdb_mis_predict  out  [NUM_CDB]  packet mispredict flag
- cdb_target_pc  out  [NUM_CDB][`XLEN]  packet target PC
- rob_enable  out  1  OR of cdb_valid

## Operation
- Push: FU i writes when fu_valid[i] && fu_ready[i]. fu_valid without fu_ready is ignored; the FU holds its data.
- fu_ready[i] = (count[i] < BUF_DEPTH), from registered count only. There is no same-cycle pop pass-through.
- Arbitration (combinational on FIFO heads): scan FU indices starting at rr_ptr, wrapping modulo NUM_FU.
  - Grant the first NUM_CDB non-empty FIFOs, at most one grant per FU per cycle.
  - Assign grants to channels 0..NUM_CDB-1 in scan order.
- Pop: every granted FIFO pops its head at the edge.
- rr_ptr update:
  - Becomes (last granted index + 1) mod NUM_FU.
  - Unchanged when nothing is granted.
- Output registers load the granted packets. Ungranted channels load cdb_valid=0, with all data fields 0.
- Simultaneous push and pop on one FIFO is legal: count is unchanged and order is preserved.
- FIFO pointers wrap at BUF_DEPTH, not at a power of two.
- squash:
  - At the edge, all counts and pointers clear and all cdb_valid clear.
  - Pushes and grants in the squash cycle are discarded.
  - rr_ptr is kept.
- reset: same clearing as squash, plus rr_ptr=0. Reset has priority over squash.

## Timing
- Reset values: cdb_valid=0, all cdb data fields 0, cdb_fu=0, rob_enable=0, fu_ready=all 1 (the cycle after reset).
- Latency: a result pushed at edge E0 reaches the output registers at edge E1 at the earliest, so it is visible one cycle after acceptance (two cycles after fu_valid first asserts).
- Throughput: up to NUM_CDB results per cycle overall, one per FU per cycle.
- Back-pressure: with BUF_DEPTH=1, an FU whose entry is granted every cycle sustains one push every other cycle, because fu_ready does not see the pop.
- Starvation bound: a non-empty FIFO is granted within ceil(NUM_FU/NUM_CDB) cycles.
- Outputs are pure register outputs. rob_enable is the OR of registered cdb_valid.

## Structure
- cdb_pkg contains:
  - typedef cdb_packet_t {value, tag, mis_predict, target_pc}, reused by the ROB and reservation-station snoop logic.
  - Default parameter constants.
- Sub-module cdb_fifo (parameter DEPTH, element cdb_packet_t) provides push/pop/squash/count/head. Instantiate NUM_FU copies.
- The arbiter and output registers live in cdb_arbiter. Count width is $clog2(BUF_DEPTH+1).

## Test plan
- Reset then idle, NUM_FU=4, NUM_CDB=1 -> cdb_valid=0, rob_enable=0, fu_ready=4'b1111.
- FU2 pushes value 0xDEAD, tag 5 at cycle 0 -> cycle 2 shows cdb_valid=1, cdb_value=0xDEAD, cdb_tag=5, cdb_fu=2 for exactly one cycle.
- All four FUs push tags 1..4 in the same cycle, rr_ptr=0 -> broadcasts appear on consecutive cycles in FU order 0,1,2,3. A second burst then starts at FU0 again.
- NUM_CDB=2, FUs 1 and 3 push together -> both appear in the same cycle: channel 0=FU1, channel 1=FU3.
- BUF_DEPTH=2: FU0 pushes 3 back-to-back while FUs 1–3 keep the bus busy -> fu_ready[0]=0 after two entries, with no loss or reordering (tags come out in push order).
- BTU FU pushes mis_predict=1, target_pc=0x400 while other FIFOs hold 3 entries. Squash the next cycle -> the packet broadcasts if already granted, after which all FIFOs are empty, cdb_valid=0 and fu_ready all 1.
